// File: rtl/psr_bank_ctrl.sv
// psr_bank_ctrl: banked program status registers (CPSR plus one SPSR per
// privileged mode). Handles prioritised exception entry through a short FSM,
// byte-masked MSR writes, exception return, and illegal-mode detection.
// The register bank reads out_cpsr[4:0] to pick its bank.
module psr_bank_ctrl #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned HAS_FIQ    = 1,
    parameter logic [31:0] RESET_PSR  = 32'h000000D3,
    parameter logic [3:0]  USER_MASK  = 4'b1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            in_exc_req,
    output logic                  out_exc_ack,
    output logic [4:0]            out_exc_mode,
    output logic                  out_busy,
    input  logic                  in_msr_valid,
    output logic                  out_msr_ready,
    input  logic                  in_msr_spsr,
    input  logic [3:0]            in_msr_mask,
    input  logic [WORD_WIDTH-1:0] in_msr_value,
    input  logic                  in_ret_valid,
    output logic [WORD_WIDTH-1:0] out_cpsr,
    output logic [WORD_WIDTH-1:0] out_spsr,
    output logic                  out_mode_err
);

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    // SPSR bank slots
    localparam logic [2:0] IDX_FIQ = 3'd0;
    localparam logic [2:0] IDX_IRQ = 3'd1;
    localparam logic [2:0] IDX_SVC = 3'd2;
    localparam logic [2:0] IDX_ABT = 3'd3;
    localparam logic [2:0] IDX_UND = 3'd4;

    localparam logic FIQ_EN = (HAS_FIQ != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // A mode encoding is legal only if it names an implemented mode.
    function automatic logic mode_legal(input logic [4:0] m);
        logic ok;
        case (m)
            MODE_USR, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND, MODE_SYS: ok = 1'b1;
            MODE_FIQ: ok = FIQ_EN;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cpsr_q, cpsr_d;
    logic [31:0] spsr_q [0:4];
    logic [31:0] spsr_d [0:4];
    logic [4:0]  tgt_mode_q, tgt_mode_d;
    logic [2:0]  tgt_idx_q, tgt_idx_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [4:0]  exc_mode_q, exc_mode_d;

    logic [31:0] msr_val;
    logic [31:0] spsr_cur;
    logic [2:0]  cur_idx;
    logic        cur_has_spsr;
    logic        cur_is_usr;
    logic [5:0]  elig;
    logic        any_elig;
    logic [2:0]  sel_src;
    logic [4:0]  sel_mode;
    logic [2:0]  sel_idx;
    logic [3:0]  cpsr_byte_en;
    logic [31:0] cpsr_merged;
    logic [31:0] spsr_merged;

    // Only the architectural low word is ever stored; upper bits read as 0.
    assign msr_val    = in_msr_value[31:0];
    assign cur_is_usr = (cpsr_q[4:0] == MODE_USR);

    // Locate the SPSR that belongs to the current mode (none in USR/SYS).
    always_comb begin
        cur_has_spsr = 1'b1;
        cur_idx      = IDX_SVC;
        case (cpsr_q[4:0])
            MODE_FIQ: begin
                cur_idx      = IDX_FIQ;
                cur_has_spsr = FIQ_EN;
            end
            MODE_IRQ: cur_idx = IDX_IRQ;
            MODE_SVC: cur_idx = IDX_SVC;
            MODE_ABT: cur_idx = IDX_ABT;
            MODE_UND: cur_idx = IDX_UND;
            default:  cur_has_spsr = 1'b0;
        endcase
    end

    assign spsr_cur = cur_has_spsr ? spsr_q[cur_idx] : 32'h0;

    // IRQ and FIQ honour the CPSR mask bits; FIQ vanishes entirely when absent.
    assign elig[0]   = in_exc_req[0];
    assign elig[1]   = in_exc_req[1] & FIQ_EN & ~cpsr_q[6];
    assign elig[2]   = in_exc_req[2] & ~cpsr_q[7];
    assign elig[5:3] = in_exc_req[5:3];
    assign any_elig  = |elig;

    // Lowest eligible index wins; map it to its target mode and SPSR slot.
    always_comb begin
        sel_src = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (elig[i]) begin
                sel_src = 3'(i);
            end
        end
        case (sel_src)
            3'd0:    begin sel_mode = MODE_ABT; sel_idx = IDX_ABT; end
            3'd1:    begin sel_mode = MODE_FIQ; sel_idx = IDX_FIQ; end
            3'd2:    begin sel_mode = MODE_IRQ; sel_idx = IDX_IRQ; end
            3'd3:    begin sel_mode = MODE_ABT; sel_idx = IDX_ABT; end
            3'd4:    begin sel_mode = MODE_UND; sel_idx = IDX_UND; end
            default: begin sel_mode = MODE_SVC; sel_idx = IDX_SVC; end
        endcase
    end

    // Byte-field merge for MSR; USR may only touch the fields in USER_MASK.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign cpsr_byte_en[gi] = in_msr_mask[gi] & (cur_is_usr ? USER_MASK[gi] : 1'b1);
            assign cpsr_merged[gi*8 +: 8] = cpsr_byte_en[gi] ? msr_val[gi*8 +: 8]
                                                             : cpsr_q[gi*8 +: 8];
            assign spsr_merged[gi*8 +: 8] = in_msr_mask[gi] ? msr_val[gi*8 +: 8]
                                                            : spsr_cur[gi*8 +: 8];
        end
    endgenerate

    // Next-state logic: exception sequencing first, then return, then MSR.
    always_comb begin
        state_d    = state_q;
        cpsr_d     = cpsr_q;
        spsr_d     = spsr_q;
        tgt_mode_d = tgt_mode_q;
        tgt_idx_d  = tgt_idx_q;
        exc_mode_d = exc_mode_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    state_d    = ST_SAVE;
                    tgt_mode_d = sel_mode;
                    tgt_idx_d  = sel_idx;
                end else if (in_ret_valid) begin
                    if (!cur_has_spsr || !mode_legal(spsr_cur[4:0])) begin
                        err_d = 1'b1;
                    end else begin
                        cpsr_d = spsr_cur;
                    end
                end else if (in_msr_valid) begin
                    if (in_msr_spsr) begin
                        if (!cur_has_spsr) begin
                            err_d = 1'b1;
                        end else begin
                            spsr_d[cur_idx] = spsr_merged;
                        end
                    end else begin
                        cpsr_d = cpsr_merged;
                        if (cpsr_byte_en[0] && !mode_legal(cpsr_merged[4:0])) begin
                            cpsr_d[4:0] = cpsr_q[4:0];
                            err_d       = 1'b1;
                        end
                    end
                end
            end
            ST_SAVE: begin
                spsr_d[tgt_idx_q] = cpsr_q;
                exc_mode_d        = tgt_mode_q;
                state_d           = ST_SWITCH;
            end
            ST_SWITCH: begin
                cpsr_d[4:0] = tgt_mode_q;
                cpsr_d[5]   = 1'b0;
                cpsr_d[7]   = 1'b1;
                if (tgt_mode_q == MODE_FIQ) begin
                    cpsr_d[6] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ack_d  = (state_d == ST_SWITCH);
        busy_d = (state_d != ST_IDLE);
    end

    // All state and registered outputs; reset abandons any entry in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cpsr_q     <= RESET_PSR;
            for (int i = 0; i < 5; i++) begin
                spsr_q[i] <= 32'h0;
            end
            tgt_mode_q <= MODE_SVC;
            tgt_idx_q  <= IDX_SVC;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            exc_mode_q <= MODE_SVC;
        end else begin
            state_q    <= state_d;
            cpsr_q     <= cpsr_d;
            for (int i = 0; i < 5; i++) begin
                spsr_q[i] <= spsr_d[i];
            end
            tgt_mode_q <= tgt_mode_d;
            tgt_idx_q  <= tgt_idx_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            exc_mode_q <= exc_mode_d;
        end
    end

    assign out_exc_ack   = ack_q;
    assign out_exc_mode  = exc_mode_q;
    assign out_busy      = busy_q;
    assign out_mode_err  = err_q;
    assign out_msr_ready = (state_q == ST_IDLE) & ~any_elig & ~in_ret_valid;
    assign out_cpsr      = WORD_WIDTH'(cpsr_q);
    assign out_spsr      = WORD_WIDTH'(spsr_cur);

endmodule

// File: tb/tb_psr_bank_ctrl.sv
// Testbench for psr_bank_ctrl: directed transactions, expected values queued
// when stimulus is driven and compared when the DUT responds.
module tb_psr_bank_ctrl;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [5:0]   in_exc_req = '0;
    logic         out_exc_ack;
    logic [4:0]   out_exc_mode;
    logic         out_busy;
    logic         in_msr_valid = 1'b0;
    logic         out_msr_ready;
    logic         in_msr_spsr = 1'b0;
    logic [3:0]   in_msr_mask = '0;
    logic [W-1:0] in_msr_value = '0;
    logic         in_ret_valid = 1'b0;
    logic [W-1:0] out_cpsr;
    logic [W-1:0] out_spsr;
    logic         out_mode_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    always #5 clock = ~clock;

    psr_bank_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .in_exc_req    (in_exc_req),
        .out_exc_ack   (out_exc_ack),
        .out_exc_mode  (out_exc_mode),
        .out_busy      (out_busy),
        .in_msr_valid  (in_msr_valid),
        .out_msr_ready (out_msr_ready),
        .in_msr_spsr   (in_msr_spsr),
        .in_msr_mask   (in_msr_mask),
        .in_msr_value  (in_msr_value),
        .in_ret_valid  (in_ret_valid),
        .out_cpsr      (out_cpsr),
        .out_spsr      (out_spsr),
        .out_mode_err  (out_mode_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.exp);
        end
    endtask

    // MSR transaction: ready in the driving cycle, CPSR/err one cycle later.
    task automatic do_msr(input string name, input logic spsr, input logic [3:0] mask,
                          input logic [31:0] val, input logic [31:0] cmask,
                          input logic [31:0] exp_cpsr, input logic exp_err);
        sb_push({name, "_ready"}, 32'd1);
        sb_push({name, "_cpsr"}, exp_cpsr & cmask);
        sb_push({name, "_err"}, 32'(exp_err));
        in_msr_valid = 1'b1;
        in_msr_spsr  = spsr;
        in_msr_mask  = mask;
        in_msr_value = val;
        #1;
        sb_pop(32'(out_msr_ready));
        @(negedge clock);
        in_msr_valid = 1'b0;
        sb_pop(out_cpsr & cmask);
        sb_pop(32'(out_mode_err));
        $display("txn msr %s spsr=%0d mask=%b val=%h -> cpsr=%h err=%0d",
                 name, spsr, mask, val, out_cpsr, out_mode_err);
    endtask

    // Exception return transaction.
    task automatic do_ret(input string name, input logic [31:0] cmask,
                          input logic [31:0] exp_cpsr, input logic exp_err);
        sb_push({name, "_cpsr"}, exp_cpsr & cmask);
        sb_push({name, "_err"}, 32'(exp_err));
        in_ret_valid = 1'b1;
        @(negedge clock);
        in_ret_valid = 1'b0;
        sb_pop(out_cpsr & cmask);
        sb_pop(32'(out_mode_err));
        $display("txn ret %s -> cpsr=%h err=%0d", name, out_cpsr, out_mode_err);
    endtask

    // Exception entry: latency, mode, then post-entry CPSR/SPSR and busy.
    task automatic do_exc(input string name, input logic [5:0] req, input logic [4:0] exp_mode,
                          input logic [31:0] exp_cpsr, input logic [31:0] exp_spsr,
                          input logic [5:0] req_after);
        int lat;
        sb_push({name, "_ready"}, 32'd0);
        sb_push({name, "_lat"}, 32'd2);
        sb_push({name, "_mode"}, 32'(exp_mode));
        sb_push({name, "_cpsr"}, exp_cpsr);
        sb_push({name, "_spsr"}, exp_spsr);
        sb_push({name, "_busy"}, 32'd0);
        in_exc_req = req;
        #1;
        sb_pop(32'(out_msr_ready));
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            lat++;
            if (out_exc_ack) break;
        end
        sb_pop(32'(lat));
        sb_pop(32'(out_exc_mode));
        in_exc_req = req_after;
        @(negedge clock);
        sb_pop(out_cpsr);
        sb_pop(out_spsr);
        sb_pop(32'(out_busy));
        $display("txn exc %s req=%b lat=%0d mode=%b cpsr=%h spsr=%h",
                 name, req, lat, out_exc_mode, out_cpsr, out_spsr);
    endtask

    initial begin
        int acks;
        // reset state
        @(negedge clock);
        @(negedge clock);
        sb_push("rst_cpsr", 32'h000000D3);
        sb_push("rst_spsr", 32'h0);
        sb_push("rst_busy", 32'd0);
        sb_push("rst_mode", 32'h13);
        sb_push("rst_ack", 32'd0);
        sb_push("rst_err", 32'd0);
        sb_pop(out_cpsr);
        sb_pop(out_spsr);
        sb_pop(32'(out_busy));
        sb_pop(32'(out_exc_mode));
        sb_pop(32'(out_exc_ack));
        sb_pop(32'(out_mode_err));
        $display("txn reset cpsr=%h mode=%b", out_cpsr, out_exc_mode);
        reset = 1'b1;
        @(negedge clock);

        // reset asserted while the FSM sits in SAVE for a DABT
        sb_push("abort_busy_save", 32'd1);
        sb_push("abort_cpsr", 32'h000000D3);
        sb_push("abort_busy", 32'd0);
        sb_push("abort_ack", 32'd0);
        sb_push("abort_ack_later", 32'd0);
        in_exc_req = 6'b000001;
        @(negedge clock);
        sb_pop(32'(out_busy));
        reset = 1'b0;
        #1;
        sb_pop(out_cpsr);
        sb_pop(32'(out_busy));
        sb_pop(32'(out_exc_ack));
        in_exc_req = '0;
        @(negedge clock);
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (out_exc_ack) acks++;
        end
        sb_pop(32'(acks));
        $display("txn reset_in_save cpsr=%h busy=%0d acks=%0d", out_cpsr, out_busy, acks);

        // SPSR_ABT must have been left at 0: enter ABT by MSR and read it
        do_msr("to_abt", 1'b0, 4'b0001, 32'h000000D7, 32'hFFFFFFFF, 32'h000000D7, 1'b0);
        check_val("spsr_abt_after_abort", out_spsr, 32'h0);
        do_msr("to_usr", 1'b0, 4'b0001, 32'h00000010, 32'hFFFFFFFF, 32'h00000010, 1'b0);

        // IRQ from USR with interrupts enabled
        do_exc("irq", 6'b000100, 5'b10010, 32'h00000092, 32'h00000010, 6'b000000);
        do_ret("ret_irq", 32'hFFFFFFFF, 32'h00000010, 1'b0);

        // FIQ beats IRQ; IRQ held afterwards stays masked
        do_exc("fiq", 6'b000110, 5'b10001, 32'h000000D1, 32'h00000010, 6'b000100);
        sb_push("irq_masked_acks", 32'd0);
        sb_push("irq_masked_busy", 32'd0);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (out_exc_ack) acks++;
        end
        sb_pop(32'(acks));
        sb_pop(32'(out_busy));
        $display("txn irq_held_in_fiq acks=%0d", acks);
        in_exc_req = '0;
        do_ret("ret_fiq", 32'hFFFFFFFF, 32'h00000010, 1'b0);

        // USR MSR: only the flags byte is writable
        do_msr("usr_cpsr", 1'b0, 4'b1111, 32'hF00000D3, 32'hFFFFFFFF, 32'hF0000010, 1'b0);
        do_msr("usr_spsr", 1'b1, 4'b1111, 32'h12345678, 32'hFFFFFFFF, 32'hF0000010, 1'b1);
        check_val("usr_spsr_reads0", out_spsr, 32'h0);
        do_ret("ret_usr", 32'hFFFFFFFF, 32'hF0000010, 1'b1);

        // SWI into SVC
        do_exc("swi", 6'b100000, 5'b10011, 32'hF0000093, 32'hF0000010, 6'b000000);

        // illegal mode by MSR in SVC: mode kept, single err pulse
        do_msr("svc_bad_mode", 1'b0, 4'b0001, 32'h00000015, 32'h0000001F, 32'h00000013, 1'b1);
        @(negedge clock);
        check_val("bad_mode_err_once", 32'(out_mode_err), 32'd0);

        // SPSR with illegal mode: SPSR write unchecked, return rejected
        do_msr("svc_spsr", 1'b1, 4'b0001, 32'h00000015, 32'h0000001F, 32'h00000013, 1'b0);
        check_val("svc_spsr_val", out_spsr, 32'hF0000015);
        do_ret("ret_bad_spsr", 32'h0000001F, 32'h00000013, 1'b1);

        // IRQ mode: return wins over a simultaneous MSR
        do_msr("to_irq", 1'b0, 4'b0001, 32'h00000012, 32'h0000001F, 32'h00000012, 1'b0);
        do_msr("irq_spsr", 1'b1, 4'b1111, 32'h20000010, 32'h0000001F, 32'h00000012, 1'b0);
        check_val("irq_spsr_val", out_spsr, 32'h20000010);
        sb_push("ret_msr_ready", 32'd0);
        sb_push("ret_msr_cpsr", 32'h20000010);
        sb_push("ret_msr_err", 32'd0);
        in_ret_valid = 1'b1;
        in_msr_valid = 1'b1;
        in_msr_spsr  = 1'b0;
        in_msr_mask  = 4'b1111;
        in_msr_value = 32'h000000D3;
        #1;
        sb_pop(32'(out_msr_ready));
        @(negedge clock);
        in_ret_valid = 1'b0;
        in_msr_valid = 1'b0;
        sb_pop(out_cpsr);
        sb_pop(32'(out_mode_err));
        $display("txn ret_with_msr cpsr=%h err=%0d", out_cpsr, out_mode_err);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
